nyq_ser_out: RTL and testbench

- Downstream consumer of the Nyquist filter stage. Accepts one decimated 24-bit sample per valid pulse and buffers it in a small FIFO.
- Serializes each sample MSB-first onto a 3-wire I2S-style link (SCK/WS/SD) for the external DAC. The same sample goes into both the left and right slots (mono).
- Uses the standard block parameter-memory interface to set the SCK divider, the enable and the attenuation.

---
 rtl/nyq_ser_out_pkg.sv | 18 +
 rtl/nyq_ser_fifo.sv | 51 +++++
 rtl/nyq_ser_out.sv | 179 +++++++++++++++++
 tb/tb_nyq_ser_out.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nyq_ser_out_pkg.sv
// Shared constants and FSM encoding for the Nyquist-stage serial output block.
package nyq_ser_out_pkg;

  localparam int unsigned ADDR_DIV   = 0;
  localparam int unsigned ADDR_EN    = 1;
  localparam int unsigned ADDR_SHIFT = 2;
  localparam int unsigned ADDR_CLR   = 3;

  localparam int unsigned SLOT_BITS = 24;
  localparam int unsigned BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_e;

endpackage

// File: rtl/nyq_ser_fifo.sv
// Synchronous sample FIFO; a push on a full FIFO only lands if a pop frees a slot that cycle.
module nyq_ser_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RBI,
  input  logic                         Flush_SI,
  input  logic                         Push_SI,
  input  logic                         Pop_SI,
  input  logic [WIDTH-1:0]             Data_DI,
  output logic [WIDTH-1:0]             Data_DO,
  output logic                         Full_SO,
  output logic                         Empty_SO,
  output logic [$clog2(DEPTH):0]       Count_DO
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign Full_SO  = (cnt_q == CW'(DEPTH));
  assign Empty_SO = (cnt_q == '0);
  assign Count_DO = cnt_q;
  assign Data_DO  = mem_q[rd_q];

  assign do_pop  = Pop_SI && !Empty_SO;
  assign do_push = Push_SI && (!Full_SO || do_pop);

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI || Flush_SI) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (do_push) mem_q[wr_q] <= Data_DI;
  end

endmodule

// File: rtl/nyq_ser_out.sv
// Mono I2S-style serializer: buffers filter samples and sends each MSB-first in both slots.
module nyq_ser_out
  import nyq_ser_out_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MEM_WIDTH  = 24,
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
  input  logic [IN_WIDTH-1:0]   SER_In_DI,
  input  logic                  SER_Valid_DI,
  output logic                  SER_Sck_DO,
  output logic                  SER_Ws_DO,
  output logic                  SER_Sd_DO,
  output logic                  SER_Empty_DO,
  output logic                  SER_Ovf_DO,
  output logic                  SER_Unf_DO
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_WIDTH-1:0] div_q;
  logic                 en_q;
  logic [2:0]           shift_q;
  logic                 ovf_q, ovf_d, unf_q, unf_d;

  state_e               state_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [BIT_CNT_W-1:0] bit_q;
  logic                 sck_q, ws_q, sd_q;
  logic [IN_WIDTH-1:0]  sh_q, cpy_q;

  logic                 wr_div, wr_en, wr_shift, wr_clr;
  logic signed [IN_WIDTH-1:0] in_s;
  logic [IN_WIDTH-1:0]  push_data, fifo_dout, load_word;
  logic                 push, pop, flush, load, shift_ev, last_bit, slot_end;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 unused_par;

  assign wr_div   = WrEn_SI && (Addr_DI == ADDR_WIDTH'(ADDR_DIV));
  assign wr_en    = WrEn_SI && (Addr_DI == ADDR_WIDTH'(ADDR_EN));
  assign wr_shift = WrEn_SI && (Addr_DI == ADDR_WIDTH'(ADDR_SHIFT));
  assign wr_clr   = WrEn_SI && (Addr_DI == ADDR_WIDTH'(ADDR_CLR));
  assign unused_par = ^PAR_In_DI[MEM_WIDTH-1:DIV_WIDTH];

  assign in_s      = SER_In_DI;
  assign push_data = in_s >>> shift_q;
  assign push      = SER_Valid_DI && en_q;

  // A shift event is the 1->0 SCK toggle; the 24th one closes the current slot.
  assign shift_ev = (state_q != ST_IDLE) && (cnt_q == div_q) && sck_q;
  assign last_bit = (bit_q == BIT_CNT_W'(SLOT_BITS - 1));
  assign slot_end = shift_ev && last_bit && (state_q == ST_RIGHT);
  assign load     = en_q && ((state_q == ST_IDLE) || slot_end);
  assign flush    = slot_end && !en_q;
  assign pop      = load && !fifo_empty;
  assign load_word = fifo_empty ? '0 : fifo_dout;

  nyq_ser_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk_CI   (Clk_CI),
    .Rst_RBI  (Rst_RBI),
    .Flush_SI (flush),
    .Push_SI  (push),
    .Pop_SI   (pop),
    .Data_DI  (push_data),
    .Data_DO  (fifo_dout),
    .Full_SO  (fifo_full),
    .Empty_SO (fifo_empty),
    .Count_DO (fifo_cnt)
  );

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (load && fifo_empty)        unf_d = 1'b1;
    if (wr_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      div_q   <= '0;
      en_q    <= 1'b0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_div)   div_q   <= PAR_In_DI[DIV_WIDTH-1:0];
      if (wr_en)    en_q    <= PAR_In_DI[0];
      if (wr_shift) shift_q <= PAR_In_DI[2:0];
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      sh_q    <= '0;
      cpy_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          sck_q <= 1'b0;
          ws_q  <= 1'b0;
          sd_q  <= 1'b0;
          if (en_q) begin
            state_q <= ST_LEFT;
            sh_q    <= load_word;
            cpy_q   <= load_word;
            sd_q    <= load_word[IN_WIDTH-1];
          end
        end
        default: begin
          if (cnt_q == div_q) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
          if (shift_ev) begin
            if (!last_bit) begin
              bit_q <= bit_q + BIT_CNT_W'(1);
              sh_q  <= {sh_q[IN_WIDTH-2:0], 1'b0};
              sd_q  <= sh_q[IN_WIDTH-2];
            end else begin
              bit_q <= '0;
              if (state_q == ST_LEFT) begin
                // Right slot replays the held copy so both slots carry the same sample.
                state_q <= ST_RIGHT;
                ws_q    <= 1'b1;
                sh_q    <= cpy_q;
                sd_q    <= cpy_q[IN_WIDTH-1];
              end else if (en_q) begin
                state_q <= ST_LEFT;
                ws_q    <= 1'b0;
                sh_q    <= load_word;
                cpy_q   <= load_word;
                sd_q    <= load_word[IN_WIDTH-1];
              end else begin
                state_q <= ST_IDLE;
                ws_q    <= 1'b0;
                sd_q    <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  assign SER_Sck_DO   = sck_q;
  assign SER_Ws_DO    = ws_q;
  assign SER_Sd_DO    = sd_q;
  assign SER_Empty_DO = (fifo_cnt == '0);
  assign SER_Ovf_DO   = ovf_q;
  assign SER_Unf_DO   = unf_q;

endmodule

// File: tb/tb_nyq_ser_out.sv
// Randomized bench for nyq_ser_out: frame-level reference model feeding a slot scoreboard.
module tb_nyq_ser_out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  addr;
  logic [23:0] par;
  logic [23:0] ser_in;
  logic        valid;
  logic        sck, ws, sd, empty, ovf, unf;

  always #5 clk = ~clk;

  nyq_ser_out dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .WrEn_SI      (wr_en),
    .Addr_DI      (addr),
    .PAR_In_DI    (par),
    .SER_In_DI    (ser_in),
    .SER_Valid_DI (valid),
    .SER_Sck_DO   (sck),
    .SER_Ws_DO    (ws),
    .SER_Sd_DO    (sd),
    .SER_Empty_DO (empty),
    .SER_Ovf_DO   (ovf),
    .SER_Unf_DO   (unf)
  );

  typedef struct packed {
    logic [23:0] w;
    logic        ws;
  } exp_t;

  int          total = 0;
  int          bad   = 0;

  // Reference model state: register file, FIFO contents and frame position in clocks.
  int          m_div;
  bit          m_en;
  int          m_shift;
  bit          m_active;
  int          m_t;
  bit          m_ovf, m_unf;
  logic [23:0] m_fifo[$];
  exp_t        exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int                 f;
    bit                 slot_end, load;
    logic [23:0]        w;
    logic signed [23:0] s;
    if (!rst_n) begin
      m_div = 0; m_en = 0; m_shift = 0; m_active = 0; m_t = 0;
      m_ovf = 0; m_unf = 0;
      m_fifo.delete();
      exp_q.delete();
    end else begin
      f        = 96 * (m_div + 1);
      slot_end = m_active && (m_t == f - 1);
      load     = m_en && (!m_active || slot_end);
      if (load) begin
        if (m_fifo.size() > 0) w = m_fifo.pop_front();
        else begin
          w = 24'h0;
          m_unf = 1;
        end
        exp_q.push_back({w, 1'b0});
        exp_q.push_back({w, 1'b1});
        m_active = 1;
        m_t = 0;
      end else if (slot_end) begin
        m_active = 0;
        m_fifo.delete();
      end else if (m_active) begin
        m_t++;
      end
      if (valid && m_en) begin
        s = ser_in;
        s = s >>> m_shift;
        if (m_fifo.size() < 4) m_fifo.push_back(s);
        else m_ovf = 1;
      end
      if (wr_en) begin
        case (addr)
          6'd0: m_div = int'(par[7:0]);
          6'd1: m_en = par[0];
          6'd2: m_shift = int'(par[2:0]);
          6'd3: begin m_ovf = 0; m_unf = 0; end
          default: ;
        endcase
      end
    end
  end

  logic        sck_prev = 1'b0;
  logic [23:0] bits = '0;
  int          nb = 0;
  exp_t        e;

  always @(negedge clk) begin : monitor
    chk("empty", empty, m_fifo.size() == 0);
    chk("ovf", ovf, m_ovf);
    chk("unf", unf, m_unf);
    if (!m_active) begin
      nb = 0;
      chk("idle_sck", sck, 0);
      chk("idle_ws", ws, 0);
      chk("idle_sd", sd, 0);
    end else if (sck && !sck_prev) begin
      bits = {bits[22:0], sd};
      if (exp_q.size() > 0) chk("slot_ws", ws, exp_q[0].ws);
      nb++;
      if (nb == 24) begin
        nb = 0;
        if (exp_q.size() == 0) chk("sb_underrun", 0, 1);
        else begin
          e = exp_q.pop_front();
          chk("slot_word", bits, e.w);
        end
      end
    end
    sck_prev = sck;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    wr_en = 1'b1; addr = a[5:0]; par = d;
    @(negedge clk);
    wr_en = 1'b0; addr = '0; par = '0;
  endtask

  task automatic push(input logic [23:0] d);
    valid = 1'b1; ser_in = d;
    @(negedge clk);
    valid = 1'b0; ser_in = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned r;
    bit          hit;
    rst_n = 1'b0; wr_en = 1'b0; addr = '0; par = '0; ser_in = '0; valid = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Disabled after reset: outputs quiet, pushes and stray addresses ignored.
    for (int i = 0; i < 200; i++) begin
      valid = 1'($urandom); ser_in = $urandom;
      @(negedge clk);
    end
    valid = 1'b0;
    wr(5, 24'hFFFFFF);
    wr(63, 24'h000001);
    idle(10);

    // DIV=0, no attenuation, single-bit edge pattern.
    wr(0, 0); wr(2, 0); wr(1, 1);
    push(24'h800001);
    idle(300);
    wr(1, 0);
    idle(200);

    // Arithmetic shift of a negative sample.
    wr(2, 2); wr(1, 1);
    push(24'hFFF000);
    idle(300);
    wr(1, 0);
    idle(200);

    // DIV=7 burst of five: fourth fills the FIFO, fifth overflows.
    wr(2, 0); wr(3, 0); wr(0, 7); wr(1, 1);
    push(24'h111111); push(24'h222222); push(24'h333333);
    push(24'h444444); push(24'h555555);
    idle(4000);
    wr(1, 0);
    idle(800);
    wr(3, 0);
    idle(5);

    // Underflow then a mid-frame push picked up at the next frame start.
    wr(0, 1); wr(1, 1);
    idle(50);
    push(24'h123456);
    idle(600);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      push($urandom);
      else if (r < 7) wr(2, 24'($urandom_range(0, 7)));
      else if (r < 8) wr(3, 0);
      else            wr(int'($urandom_range(4, 63)), $urandom);
      idle(int'($urandom_range(0, 120)));
    end

    // Drop EN around bit 10 of a left slot: frame completes, then IDLE with FIFO flushed.
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      if (m_active && m_t == 20 * (m_div + 1)) hit = 1;
      else @(negedge clk);
    end
    chk("en_wait", hit, 1);
    push(24'hABCDEF);
    wr(1, 0);
    idle(2 * 192 + 20);
    chk("drain", exp_q.size(), 0);

    // Reset in the middle of a frame.
    wr(1, 1);
    push(24'h5A5A5A);
    idle(100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
